// File: rtl/ysyx_23060072_pcu.sv
// PC register and IF/ID capture for the rv32e fetch stage, with redirect, stall and ebreak halt.
// Define YSYX_23060072_BTFN_EN for static backward-taken/forward-not-taken branch prediction.
module ysyx_23060072_pcu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] instr_addr_o,
    input  logic [31:0] inst_rdata_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_pred_taken_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        adv_c;
    logic        pred_c;
    logic [31:0] next_pc_c;
    logic [31:0] redirect_target_c;

    assign instr_addr_o      = pc;
    assign adv_c             = (state == RUN) && (!id_valid_o || id_ready_i);
    assign redirect_target_c = redirect_pc_i & ~32'd3;

`ifdef YSYX_23060072_BTFN_EN
    logic [31:0] imm_b_c;

    // Backward conditional branches are predicted taken, everything else falls through.
    always_comb begin
        imm_b_c   = {{20{inst_rdata_i[31]}}, inst_rdata_i[7], inst_rdata_i[30:25],
                     inst_rdata_i[11:8], 1'b0};
        pred_c    = (inst_rdata_i[6:0] == 7'b1100011) && inst_rdata_i[31];
        next_pc_c = pred_c ? (pc + imm_b_c) : (pc + 32'd4);
    end
`else
    assign pred_c    = 1'b0;
    assign next_pc_c = pc + 32'd4;
`endif

    // Priority: reset, redirect, advance, then drain of the held instruction while halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc              <= RESET_PC;
            state           <= RUN;
            id_valid_o      <= 1'b0;
            id_pc_o         <= 32'd0;
            id_inst_o       <= NOP_INST;
            id_pred_taken_o <= 1'b0;
        end else if (redirect_i) begin
            pc              <= redirect_target_c;
            state           <= RUN;
            id_valid_o      <= 1'b0;
            id_inst_o       <= NOP_INST;
            id_pred_taken_o <= 1'b0;
        end else if (adv_c) begin
            pc              <= next_pc_c;
            id_valid_o      <= 1'b1;
            id_pc_o         <= pc;
            id_inst_o       <= inst_rdata_i;
            id_pred_taken_o <= pred_c;
            if (inst_rdata_i == EBREAK_INST) begin
                state <= HALT;
            end
        end else if (id_valid_o && id_ready_i) begin
            id_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_23060072_pcu.sv
// Bench for ysyx_23060072_pcu: directed vector table followed by randomized run against a reference model.
module tb_ysyx_23060072_pcu;

    localparam logic [31:0] B      = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBRK   = 32'h0010_0073;
    localparam logic [31:0] BEQ_BK = 32'hFE00_0CE3;
    localparam logic [31:0] BEQ_FW = 32'h0000_0463;
`ifdef YSYX_23060072_BTFN_EN
    localparam bit BTFN = 1'b1;
`else
    localparam bit BTFN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_addr;
    logic [31:0] inst_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_pred;
    logic        redirect;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_23060072_pcu dut (
        .clk            (clk),
        .rst            (rst),
        .instr_addr_o   (instr_addr),
        .inst_rdata_i   (inst_rdata),
        .id_valid_o     (id_valid),
        .id_ready_i     (id_ready),
        .id_pc_o        (id_pc),
        .id_inst_o      (id_inst),
        .id_pred_taken_o(id_pred),
        .redirect_i     (redirect),
        .redirect_pc_i  (redirect_pc)
    );

    // Every ordinary ROM word is a distinct addi so the fetched address is visible in the instruction.
    function automatic logic [31:0] addi_at(input logic [31:0] a);
        return {a[13:2], 5'd1, 3'd0, 5'd1, 7'h13};
    endfunction

    function automatic logic [31:0] rom_f(input logic [31:0] a);
        if (a == B + 32'h10) return EBRK;
        if (a == B + 32'h20) return BEQ_BK;
        if (a == B + 32'h30) return BEQ_FW;
        return addi_at(a);
    endfunction

    always_comb inst_rdata = rom_f(instr_addr);

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        red;
        logic [31:0] rpc;
        logic        rdy;
        logic [31:0] addr;
        logic        v;
        logic        chk_pc;
        logic [31:0] idpc;
        logic [31:0] inst;
        logic        pred;
    } vec_t;

    function automatic vec_t mkv(input logic r, input logic rd, input logic [31:0] rp, input logic rdy,
                                 input logic [31:0] ad, input logic v, input logic cp,
                                 input logic [31:0] ip, input logic [31:0] in, input logic pr);
        vec_t x;
        x.rst = r; x.red = rd; x.rpc = rp; x.rdy = rdy;
        x.addr = ad; x.v = v; x.chk_pc = cp; x.idpc = ip; x.inst = in; x.pred = pr;
        return x;
    endfunction

    // Reference model state: what the stage should hold after each edge.
    logic [31:0] m_pc, m_idpc, m_inst;
    logic        m_v, m_pred, m_halt;

    task automatic model_step(input logic r, input logic rd, input logic [31:0] rp, input logic rdy);
        logic [31:0] ins;
        logic [12:0] raw;
        int          off;
        bit          taken;
        if (r) begin
            m_pc = B; m_v = 0; m_idpc = 0; m_inst = NOP; m_pred = 0; m_halt = 0;
        end else if (rd) begin
            m_pc = rp - (rp % 4); m_halt = 0; m_v = 0; m_inst = NOP; m_pred = 0;
        end else if (!m_halt && (!m_v || rdy)) begin
            ins   = rom_f(m_pc);
            taken = BTFN && (ins[6:0] == 7'h63) && ins[31];
            raw   = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            off   = ins[31] ? int'(raw) - 8192 : int'(raw);
            m_v = 1; m_idpc = m_pc; m_inst = ins; m_pred = taken;
            m_pc = taken ? m_pc + 32'(off) : m_pc + 32'd4;
            if (ins == EBRK) m_halt = 1;
        end else if (m_v && rdy) begin
            m_v = 0;
        end
    endtask

    task automatic drive(input logic r, input logic rd, input logic [31:0] rp, input logic rdy);
        @(negedge clk);
        rst = r; redirect = rd; redirect_pc = rp; id_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[25];

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; id_ready = 1'b0;

        tbl[0]  = mkv(1, 0, 0,            1, B,        0, 1, 0,         NOP,              0);
        tbl[1]  = mkv(0, 0, 0,            1, B + 4,    1, 1, B,         addi_at(B),       0);
        tbl[2]  = mkv(0, 0, 0,            1, B + 8,    1, 1, B + 4,     addi_at(B + 4),   0);
        tbl[3]  = mkv(0, 0, 0,            1, B + 12,   1, 1, B + 8,     addi_at(B + 8),   0);
        tbl[4]  = mkv(0, 0, 0,            0, B + 12,   1, 1, B + 8,     addi_at(B + 8),   0);
        tbl[5]  = mkv(0, 0, 0,            0, B + 12,   1, 1, B + 8,     addi_at(B + 8),   0);
        tbl[6]  = mkv(0, 0, 0,            0, B + 12,   1, 1, B + 8,     addi_at(B + 8),   0);
        tbl[7]  = mkv(0, 0, 0,            1, B + 16,   1, 1, B + 12,    addi_at(B + 12),  0);
        tbl[8]  = mkv(0, 0, 0,            1, B + 20,   1, 1, B + 16,    EBRK,             0);
        tbl[9]  = mkv(0, 0, 0,            0, B + 20,   1, 1, B + 16,    EBRK,             0);
        tbl[10] = mkv(0, 0, 0,            1, B + 20,   0, 0, 0,         EBRK,             0);
        tbl[11] = mkv(0, 0, 0,            1, B + 20,   0, 0, 0,         EBRK,             0);
        tbl[12] = mkv(0, 1, B,            1, B,        0, 0, 0,         NOP,              0);
        tbl[13] = mkv(0, 0, 0,            1, B + 4,    1, 1, B,         addi_at(B),       0);
        tbl[14] = mkv(0, 0, 0,            0, B + 4,    1, 1, B,         addi_at(B),       0);
        tbl[15] = mkv(0, 1, B + 32'h42,   0, B + 32'h40, 0, 0, 0,       NOP,              0);
        tbl[16] = mkv(0, 0, 0,            0, B + 32'h44, 1, 1, B + 32'h40, addi_at(B + 32'h40), 0);
        tbl[17] = mkv(0, 0, 0,            1, B + 32'h48, 1, 1, B + 32'h44, addi_at(B + 32'h44), 0);
        tbl[18] = mkv(0, 1, B + 32'h20,   1, B + 32'h20, 0, 0, 0,       NOP,              0);
        tbl[19] = mkv(0, 0, 0,            1, BTFN ? B + 32'h18 : B + 32'h24, 1, 1, B + 32'h20, BEQ_BK, BTFN);
        tbl[20] = mkv(0, 1, B + 32'h30,   1, B + 32'h30, 0, 0, 0,       NOP,              0);
        tbl[21] = mkv(0, 0, 0,            1, B + 32'h34, 1, 1, B + 32'h30, BEQ_FW,        0);
        tbl[22] = mkv(0, 1, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFC, 0, 0, 0,   NOP,              0);
        tbl[23] = mkv(0, 0, 0,            1, 32'h0,    1, 1, 32'hFFFF_FFFC, addi_at(32'hFFFF_FFFC), 0);
        tbl[24] = mkv(1, 1, B + 32'h42,   0, B,        0, 1, 0,         NOP,              0);

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].rst, tbl[i].red, tbl[i].rpc, tbl[i].rdy);
            chk32($sformatf("vec%0d addr", i), instr_addr, tbl[i].addr);
            chk32($sformatf("vec%0d valid", i), 32'(id_valid), 32'(tbl[i].v));
            if (tbl[i].chk_pc) chk32($sformatf("vec%0d id_pc", i), id_pc, tbl[i].idpc);
            chk32($sformatf("vec%0d id_inst", i), id_inst, tbl[i].inst);
            chk32($sformatf("vec%0d pred", i), 32'(id_pred), 32'(tbl[i].pred));
        end

        // Randomized run: the first cycle resets so DUT and model start aligned.
        for (int i = 0; i < 3000; i++) begin
            logic        r, rd, rdy;
            logic [31:0] rp;
            r   = (i == 0) || ($urandom_range(0, 63) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            rp  = ($urandom_range(0, 3) == 3) ? $urandom : B + 32'($urandom_range(0, 63));
            rdy = ($urandom_range(0, 3) != 0);
            model_step(r, rd, rp, rdy);
            drive(r, rd, rp, rdy);
            chk32("rnd addr", instr_addr, m_pc);
            chk32("rnd valid", 32'(id_valid), 32'(m_v));
            if (m_v) chk32("rnd id_pc", id_pc, m_idpc);
            chk32("rnd id_inst", id_inst, m_inst);
            chk32("rnd pred", 32'(id_pred), 32'(m_pred));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
